// File: rtl/ray_march_seq.sv
// ray_march_seq: sphere-tracing ray marcher that sequences distance queries to an external scene unit
module ray_march_seq #(
    parameter int W         = 32,
    parameter int FRAC      = 16,
    parameter int MAX_STEPS = 100,
    parameter int MAX_DIST  = 100 << FRAC,
    parameter int SURF_DIST = 655
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3*W-1:0]   ro,
    input  logic [3*W-1:0]   rd,
    output logic             busy,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [3*W-1:0]   q_pos,
    input  logic             r_valid,
    input  logic [W-1:0]     r_dist,
    output logic             done,
    output logic             hit,
    output logic [W-1:0]     distance,
    output logic [15:0]      steps
);
    typedef enum logic [2:0] {IDLE, POS, REQ, WAIT, ACC, FIN} state_t;
    localparam logic signed [W-1:0] max_d  = W'(MAX_DIST);
    localparam logic signed [W-1:0] surf_d = W'(SURF_DIST);
    localparam logic [15:0]         max_s  = 16'(MAX_STEPS);
    state_t                 state, nxt;
    logic [3*W-1:0]         ro_r, rd_r, pos_n;
    logic signed [W-1:0]    ray_dist, ds, new_dist;
    logic [15:0]            cnt;
    logic                   is_hit, is_far, is_last, fin;
    // Per-axis query point ro + rd*t; low W bits of the product shifted by FRAC equal the truncated arithmetic shift
    for (genvar i = 0; i < 3; i++) begin : g_axis
        logic signed [2*W-1:0] prod;
        assign prod = $signed({{W{rd_r[i*W+W-1]}}, rd_r[i*W +: W]}) * $signed({{W{ray_dist[W-1]}}, ray_dist});
        assign pos_n[i*W +: W] = ro_r[i*W +: W] + prod[FRAC +: W];
    end
    assign new_dist = ray_dist + ds;
    assign is_hit   = ds < surf_d;
    assign is_far   = new_dist > max_d;
    assign is_last  = cnt == max_s;
    assign fin      = is_hit || is_far || is_last;
    assign busy     = state != IDLE;
    assign q_valid  = state == REQ;
    assign done     = state == FIN;
    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end
    // Next-state logic for the march sequence
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? POS : IDLE;
            POS:     nxt = REQ;
            REQ:     nxt = q_ready ? WAIT : REQ;
            WAIT:    nxt = r_valid ? ACC : WAIT;
            ACC:     nxt = fin ? FIN : POS;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Ray datapath; results are written on the ACC->FIN step so they are visible alongside done
    always_ff @(posedge clk) begin
        if (rst) begin
            ro_r     <= '0;
            rd_r     <= '0;
            ray_dist <= '0;
            ds       <= '0;
            cnt      <= '0;
            q_pos    <= '0;
            hit      <= 1'b0;
            distance <= '0;
            steps    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ro_r     <= ro;
                    rd_r     <= rd;
                    ray_dist <= '0;
                    cnt      <= '0;
                end
                POS:  q_pos <= pos_n;
                REQ:  if (q_ready) cnt <= cnt + 16'd1;
                WAIT: if (r_valid) ds <= r_dist;
                ACC: begin
                    ray_dist <= new_dist;
                    if (fin) begin
                        hit      <= is_hit;
                        distance <= new_dist;
                        steps    <= cnt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_march_seq.sv
// tb_ray_march_seq: directed checks of the ray marcher against a scripted scene unit
module tb_ray_march_seq;
    logic        clk = 1'b0;
    logic        rst, start, q_ready, r_valid;
    logic [95:0] ro, rd, q_pos;
    logic [31:0] r_dist, distance;
    logic        busy, q_valid, done, hit;
    logic [15:0] steps;
    int          n_chk = 0, n_fail = 0, nq;
    logic [31:0] resp [8];
    logic [95:0] qlog [8];
    logic        got_hit;
    logic [31:0] got_dist;
    logic [15:0] got_steps;
    localparam logic [95:0] RO0  = '0;
    localparam logic [95:0] RDZ  = {32'h0001_0000, 32'h0, 32'h0};
    localparam logic [95:0] RO2  = {32'h0, 32'h0, 32'h0002_0000};
    localparam logic [95:0] RDXY = {32'h0, 32'hFFFF_0000, 32'h0000_8000};

    ray_march_seq #(.MAX_STEPS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ro(ro), .rd(rd), .busy(busy),
        .q_valid(q_valid), .q_ready(q_ready), .q_pos(q_pos), .r_valid(r_valid),
        .r_dist(r_dist), .done(done), .hit(hit), .distance(distance), .steps(steps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] b);
        resp[0] = a;
        for (int k = 1; k < 8; k++) resp[k] = b;
    endtask

    task automatic run_ray(input logic [95:0] o, input logic [95:0] d, input int qd, input int rdl);
        bit          fin_seen = 0;
        logic [95:0] p;
        nq = 0;
        @(negedge clk);
        ro = o; rd = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && !fin_seen; c++) begin
            if (done) begin
                fin_seen  = 1;
                got_hit   = hit;
                got_dist  = distance;
                got_steps = steps;
            end else if (q_valid) begin
                p = q_pos;
                for (int k = 0; k < qd; k++) begin
                    start = (k == 1);
                    if (k == 1) begin ro = '1; rd = '1; end
                    @(negedge clk);
                    check("qpos_stable", q_pos, p);
                    check("qvalid_held", q_valid, 1);
                end
                start = 1'b0;
                if (nq < 8) qlog[nq] = q_pos;
                q_ready = 1'b1;
                @(negedge clk);
                q_ready = 1'b0;
                repeat (rdl) @(negedge clk);
                r_dist  = resp[nq < 8 ? nq : 7];
                r_valid = 1'b1;
                nq++;
                @(negedge clk);
                r_valid = 1'b0;
            end else @(negedge clk);
        end
        check("done_seen", fin_seen, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    task automatic expect_hit_ray(input string tag);
        check({tag, "_nq"}, nq, 2);
        check({tag, "_q0"}, qlog[0], RO0);
        check({tag, "_q1"}, qlog[1], {32'h0005_0000, 64'h0});
        check({tag, "_hit"}, got_hit, 1);
        check({tag, "_dist"}, got_dist, 32'h0005_0000);
        check({tag, "_steps"}, got_steps, 2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; q_ready = 1'b0; r_valid = 1'b0;
        ro = '0; rd = '0; r_dist = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_qvalid", q_valid, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_dist", distance, 0);
        check("rst_steps", steps, 0);
        check("rst_qpos", q_pos, 0);
        rst = 1'b0;

        fill(32'h0005_0000, 32'h0);
        run_ray(RO0, RDZ, 0, 0);
        expect_hit_ray("hit");

        fill(32'h003C_0000, 32'h003C_0000);
        run_ray(RO0, RDZ, 0, 0);
        check("miss_q1", qlog[1], {32'h003C_0000, 64'h0});
        check("miss_hit", got_hit, 0);
        check("miss_dist", got_dist, 32'h0078_0000);
        check("miss_steps", got_steps, 2);

        fill(32'h0001_0000, 32'h0001_0000);
        run_ray(RO0, RDZ, 0, 0);
        check("lim_nq", nq, 4);
        check("lim_q3", qlog[3], {32'h0003_0000, 64'h0});
        check("lim_hit", got_hit, 0);
        check("lim_dist", got_dist, 32'h0004_0000);
        check("lim_steps", got_steps, 4);

        fill(32'h0005_0000, 32'h0);
        run_ray(RO2, RDXY, 0, 0);
        check("xy_q0", qlog[0], RO2);
        check("xy_q1", qlog[1], {32'h0, 32'hFFFB_0000, 32'h0004_8000});
        check("xy_hit", got_hit, 1);

        fill(32'h0005_0000, 32'h0);
        run_ray(RO0, RDZ, 7, 5);
        expect_hit_ray("bp");

        fill(32'hFFFF_8000, 32'h0);
        run_ray(RO0, RDZ, 0, 0);
        check("neg_hit", got_hit, 1);
        check("neg_dist", got_dist, 32'hFFFF_8000);
        check("neg_steps", got_steps, 1);

        @(negedge clk);
        ro = RO0; rd = RDZ; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !q_valid; c++) @(negedge clk);
        check("rw_qvalid", q_valid, 1);
        q_ready = 1'b1;
        @(negedge clk);
        q_ready = 1'b0;
        check("rw_busy_wait", busy, 1);
        rst = 1'b1; r_valid = 1'b1; r_dist = 32'h0;
        @(negedge clk);
        rst = 1'b0; r_valid = 1'b0;
        check("rw_busy", busy, 0);
        check("rw_done", done, 0);
        check("rw_steps", steps, 0);
        check("rw_qpos", q_pos, 0);
        @(negedge clk);
        check("rw_done2", done, 0);
        r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        check("stray_busy", busy, 0);
        @(negedge clk);
        check("stray_busy2", busy, 0);
        check("stray_done", done, 0);

        fill(32'h0005_0000, 32'h0);
        run_ray(RO0, RDZ, 0, 0);
        expect_hit_ray("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
